// File: rtl/result_ascii_writer_if.sv
// result_ascii_writer_if
//   Bundles the calculator-side trigger (finish, result) and the typewriter-side
//   character stream (ascii_out, char_valid) with the writer status (busy, done).
//   master : calculator / typewriter side (drives finish and result)
//   slave  : result_ascii_writer (drives the character stream and status)
interface result_ascii_writer_if;
   logic        finish;
   logic [15:0] result;
   logic [7:0]  ascii_out;
   logic        char_valid;
   logic        busy;
   logic        done;

   modport master (
      output finish, result,
      input  ascii_out, char_valid, busy, done
   );

   modport slave (
      input  finish, result,
      output ascii_out, char_valid, busy, done
   );
endinterface

// File: rtl/result_ascii_writer.sv
// result_ascii_writer
//   Takes the 16-bit calculator result on a rising edge of finish and streams it
//   to the VGA typewriter as ASCII: optional '=', optional '-', then the decimal
//   digits MSD-first with leading zeros suppressed. Binary-to-decimal is a
//   sequential double-dabble (16 iterations). Each character is a one-cycle
//   char_valid strobe, and consecutive strobes are GAP_CYCLES+1 clocks apart.
//
// Ports
//   clk_50m : system clock
//   rst     : synchronous active-high reset
//   bus     : result_ascii_writer_if.slave
//             finish/result in; ascii_out/char_valid/busy/done out
//
// Parameters
//   GAP_CYCLES  : idle cycles between strobes (1..255)
//   EMIT_PREFIX : 1 = emit '=' before the number
//
// Build option
//   SIGNED_RESULT_EN : result is two's complement; negative values emit '-'
//                      and the magnitude. Undefined: result is unsigned.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | waiting for a finish rising edge
// S_CONVERT| one double-dabble iteration per clock, 16 in total
// S_EMIT   | strobe the current character
// S_GAP    | hold off GAP_CYCLES clocks after a strobe
// S_DONE   | one-cycle exit: pulse done, drop busy
module result_ascii_writer #(
   parameter int GAP_CYCLES  = 4,
   parameter bit EMIT_PREFIX = 1'b1
) (
   input logic                  clk_50m,
   input logic                  rst,
   result_ascii_writer_if.slave bus
);

   typedef enum logic [2:0] {S_IDLE, S_CONVERT, S_EMIT, S_GAP, S_DONE} state_t;

   // Character slots: 0 '=', 1 '-', 2..6 BCD digits 4..0 (slot 6 is the units digit).
   localparam logic [2:0] SLOT_EQ    = 3'd0;
   localparam logic [2:0] SLOT_MINUS = 3'd1;
   localparam logic [2:0] SLOT_LAST  = 3'd6;

   state_t      state, state_nxt;
   logic        finish_d, start;
   logic [19:0] bcd, bcd_adj, bcd_nxt;
   logic [15:0] bin, mag_in;
   logic        neg, neg_in;
   logic [3:0]  iter_cnt;
   logic [7:0]  gap_cnt;
   logic [2:0]  slot, slot_nxt, digit_slot, msd_slot, first_slot;
   logic        last_sent;
   logic [7:0]  char_code, ascii_q;
   logic        char_valid_q, busy_q, done_q;

`ifdef SIGNED_RESULT_EN
   // Negation happens in the latch cycle so the strobe latency is unchanged.
   assign neg_in = bus.result[15];
   assign mag_in = bus.result[15] ? 16'(16'd0 - bus.result) : bus.result;
`else
   assign neg_in = 1'b0;
   assign mag_in = bus.result;
`endif

   assign start = bus.finish & ~finish_d;

   always_comb begin
      bcd_adj = bcd;
      for (int i = 0; i < 5; i++) begin
         if (bcd[i*4 +: 4] >= 4'd5)
            bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
      end
   end

   assign bcd_nxt = {bcd_adj[18:0], bin[15]};

   // Leading-zero suppression works on the value after the final iteration,
   // so a zero result still produces the units digit.
   always_comb begin
      msd_slot = SLOT_LAST;
      if      (bcd_nxt[19:16] != 4'd0) msd_slot = 3'd2;
      else if (bcd_nxt[15:12] != 4'd0) msd_slot = 3'd3;
      else if (bcd_nxt[11:8]  != 4'd0) msd_slot = 3'd4;
      else if (bcd_nxt[7:4]   != 4'd0) msd_slot = 3'd5;
   end

   always_comb begin
      first_slot = msd_slot;
      if (EMIT_PREFIX)
         first_slot = SLOT_EQ;
      else if (neg)
         first_slot = SLOT_MINUS;
   end

   always_comb begin
      slot_nxt = slot + 3'd1;
      case (slot)
         SLOT_EQ:    slot_nxt = neg ? SLOT_MINUS : digit_slot;
         SLOT_MINUS: slot_nxt = digit_slot;
         default:    slot_nxt = slot + 3'd1;
      endcase
   end

   always_comb begin
      char_code = 8'h30;
      case (slot)
         3'd0:    char_code = 8'h3D;
         3'd1:    char_code = 8'h2D;
         3'd2:    char_code = {4'h3, bcd[19:16]};
         3'd3:    char_code = {4'h3, bcd[15:12]};
         3'd4:    char_code = {4'h3, bcd[11:8]};
         3'd5:    char_code = {4'h3, bcd[7:4]};
         default: char_code = {4'h3, bcd[3:0]};
      endcase
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:    if (start) state_nxt = S_CONVERT;
         S_CONVERT: if (iter_cnt == 4'd15) state_nxt = S_EMIT;
         S_EMIT:    state_nxt = S_GAP;
         S_GAP:     if (gap_cnt == 8'd0) state_nxt = last_sent ? S_DONE : S_EMIT;
         S_DONE:    state_nxt = S_IDLE;
         default:   state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_50m) begin
      if (rst) begin
         state        <= S_IDLE;
         finish_d     <= 1'b0;
         bcd          <= '0;
         bin          <= '0;
         neg          <= 1'b0;
         iter_cnt     <= '0;
         gap_cnt      <= '0;
         slot         <= '0;
         digit_slot   <= '0;
         last_sent    <= 1'b0;
         ascii_q      <= 8'h00;
         char_valid_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state        <= state_nxt;
         finish_d     <= bus.finish;
         char_valid_q <= 1'b0;
         done_q       <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  busy_q    <= 1'b1;
                  bin       <= mag_in;
                  neg       <= neg_in;
                  bcd       <= '0;
                  iter_cnt  <= '0;
                  last_sent <= 1'b0;
               end
            end
            S_CONVERT: begin
               bcd      <= bcd_nxt;
               bin      <= {bin[14:0], 1'b0};
               iter_cnt <= iter_cnt + 4'd1;
               if (iter_cnt == 4'd15) begin
                  digit_slot <= msd_slot;
                  slot       <= first_slot;
               end
            end
            S_EMIT: begin
               char_valid_q <= 1'b1;
               ascii_q      <= char_code;
               gap_cnt      <= 8'(GAP_CYCLES - 1);
               if (slot == SLOT_LAST)
                  last_sent <= 1'b1;
               else
                  slot <= slot_nxt;
            end
            S_GAP: begin
               if (gap_cnt != 8'd0)
                  gap_cnt <= gap_cnt - 8'd1;
            end
            S_DONE: begin
               done_q <= 1'b1;
               busy_q <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign bus.ascii_out  = ascii_q;
   assign bus.char_valid = char_valid_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;

endmodule

// File: tb/tb_result_ascii_writer.sv
// tb_result_ascii_writer
//   Drives two writers (with and without the '=' prefix) and compares the
//   captured character stream, strobe timing and status against a decimal
//   string model of the result.
module tb_result_ascii_writer;
   localparam int GAP = 4;

   logic clk_50m = 1'b0;
   logic rst;
   always #10 clk_50m = ~clk_50m;

   result_ascii_writer_if bus_a ();
   result_ascii_writer_if bus_b ();

   result_ascii_writer #(.GAP_CYCLES(GAP), .EMIT_PREFIX(1'b1)) dut_a (
      .clk_50m (clk_50m),
      .rst     (rst),
      .bus     (bus_a)
   );

   result_ascii_writer #(.GAP_CYCLES(GAP), .EMIT_PREFIX(1'b0)) dut_b (
      .clk_50m (clk_50m),
      .rst     (rst),
      .bus     (bus_b)
   );

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   always @(posedge clk_50m) cyc <= cyc + 1;

   logic [7:0] cap_a[$];
   int         tim_a[$];
   int         done_a[$];
   logic [7:0] cap_b[$];
   int         tim_b[$];
   int         done_b[$];
   bit         consec_seen = 1'b0;
   bit         cr_seen     = 1'b0;
   logic       prev_a      = 1'b0;
   logic       prev_b      = 1'b0;

   always @(negedge clk_50m) begin
      if (bus_a.char_valid === 1'b1) begin
         cap_a.push_back(bus_a.ascii_out);
         tim_a.push_back(cyc);
         if (bus_a.ascii_out == 8'h0D) cr_seen = 1'b1;
         if (prev_a === 1'b1) consec_seen = 1'b1;
      end
      prev_a = bus_a.char_valid;
      if (bus_a.done === 1'b1) done_a.push_back(cyc);
      if (bus_b.char_valid === 1'b1) begin
         cap_b.push_back(bus_b.ascii_out);
         tim_b.push_back(cyc);
         if (bus_b.ascii_out == 8'h0D) cr_seen = 1'b1;
         if (prev_b === 1'b1) consec_seen = 1'b1;
      end
      prev_b = bus_b.char_valid;
      if (bus_b.done === 1'b1) done_b.push_back(cyc);
   end

   // Expected text: optional '=', optional '-', then the decimal value.
   function automatic string model_str(input logic [15:0] v, input bit pfx);
      string s;
      int    m;
      s = "";
      if (pfx) s = "=";
      m = int'(v);
`ifdef SIGNED_RESULT_EN
      if (v[15]) begin
         s = {s, "-"};
         m = 65536 - m;
      end
`endif
      s = {s, $sformatf("%0d", m)};
      return s;
   endfunction

   task automatic tick();
      @(negedge clk_50m);
      #1;
   endtask

   task automatic clear_caps();
      cap_a.delete(); tim_a.delete(); done_a.delete();
      cap_b.delete(); tim_b.delete(); done_b.delete();
   endtask

   // Low-then-high on finish; n is the edge that samples the rising edge.
   task automatic launch(input bit sel_b, input logic [15:0] v, output int n);
      tick();
      if (sel_b) bus_b.finish = 1'b0; else bus_a.finish = 1'b0;
      tick();
      clear_caps();
      if (sel_b) begin bus_b.result = v; bus_b.finish = 1'b1; end
      else       begin bus_a.result = v; bus_a.finish = 1'b1; end
      n = cyc + 1;
   endtask

   task automatic wait_done(input bit sel_b, input string tag);
      int k = 0;
      while (((sel_b ? done_b.size() : done_a.size()) == 0) && k < 1000) begin
         tick();
         k++;
      end
      checks++;
      if ((sel_b ? done_b.size() : done_a.size()) == 0) begin
         errors++;
         $display("FAIL %s done_timeout: no done within %0d cycles", tag, k);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus_a.finish = 1'b0; bus_a.result = '0;
      bus_b.finish = 1'b0; bus_b.result = '0;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      checks++;
      if ({bus_a.ascii_out, bus_a.char_valid, bus_a.busy, bus_a.done} !== 11'h0) begin
         errors++;
         $display("FAIL reset_a: got ascii=%h cv=%b busy=%b done=%b want all 0",
                  bus_a.ascii_out, bus_a.char_valid, bus_a.busy, bus_a.done);
      end
      checks++;
      if ({bus_b.ascii_out, bus_b.char_valid, bus_b.busy, bus_b.done} !== 11'h0) begin
         errors++;
         $display("FAIL reset_b: got ascii=%h cv=%b busy=%b done=%b want all 0",
                  bus_b.ascii_out, bus_b.char_valid, bus_b.busy, bus_b.done);
      end
   endtask

   task automatic test_basic();
      int    n;
      string exp;
      exp = model_str(16'd1234, 1'b1);
      launch(1'b0, 16'd1234, n);
      tick();
      checks++;
      if (bus_a.busy !== 1'b1) begin
         errors++;
         $display("FAIL basic_busy_at_start: got %b want 1", bus_a.busy);
      end
      wait_done(1'b0, "basic");
      tick();
      checks++;
      if (cap_a.size() != exp.len()) begin
         errors++;
         $display("FAIL basic_len: got %0d want %0d", cap_a.size(), exp.len());
      end
      for (int i = 0; i < cap_a.size() && i < exp.len(); i++) begin
         checks++;
         if (cap_a[i] !== 8'(exp[i])) begin
            errors++;
            $display("FAIL basic_char%0d: got %h want %h", i, cap_a[i], 8'(exp[i]));
         end
         checks++;
         if (tim_a[i] != n + 17 + i * (GAP + 1)) begin
            errors++;
            $display("FAIL basic_time%0d: got edge %0d want %0d", i, tim_a[i] - n,
                     17 + i * (GAP + 1));
         end
      end
      if (tim_a.size() > 0 && done_a.size() > 0) begin
         checks++;
         if (done_a[0] != tim_a[tim_a.size()-1] + GAP + 1) begin
            errors++;
            $display("FAIL basic_done_time: got %0d want %0d", done_a[0],
                     tim_a[tim_a.size()-1] + GAP + 1);
         end
      end
      checks++;
      if (bus_a.busy !== 1'b0 || bus_a.ascii_out !== 8'h34) begin
         errors++;
         $display("FAIL basic_after_done: got busy=%b ascii=%h want busy=0 ascii=34",
                  bus_a.busy, bus_a.ascii_out);
      end
   endtask

   task automatic check_string(input bit sel_b, input logic [15:0] v, input string tag);
      string exp;
      int    sz;
      exp = model_str(v, !sel_b);
      sz  = sel_b ? cap_b.size() : cap_a.size();
      checks++;
      if (sz != exp.len()) begin
         errors++;
         $display("FAIL %s_len v=%h: got %0d want %0d", tag, v, sz, exp.len());
      end
      for (int i = 0; i < sz && i < exp.len(); i++) begin
         checks++;
         if ((sel_b ? cap_b[i] : cap_a[i]) !== 8'(exp[i])) begin
            errors++;
            $display("FAIL %s_char%0d v=%h: got %h want %h", tag, i, v,
                     sel_b ? cap_b[i] : cap_a[i], 8'(exp[i]));
         end
      end
   endtask

   task automatic test_values();
      int          n;
      logic [15:0] vals[$];
      vals = '{16'd0, 16'd65535, 16'd9, 16'd10, 16'd100, 16'hFFF6, 16'h8000};
      repeat (6) vals.push_back(16'($urandom_range(0, 65535)));
      foreach (vals[j]) begin
         launch(1'b0, vals[j], n);
         wait_done(1'b0, "values");
         tick();
         check_string(1'b0, vals[j], "values");
         checks++;
         if (tim_a.size() == 0 || tim_a[0] != n + 17) begin
            errors++;
            $display("FAIL values_first_strobe v=%h: got edge %0d want 17", vals[j],
                     tim_a.size() == 0 ? -1 : tim_a[0] - n);
         end
      end
   endtask

   task automatic test_no_prefix();
      int          n;
      logic [15:0] vals[$];
      vals = '{16'd7, 16'd0, 16'hFFF6};
      repeat (3) vals.push_back(16'($urandom_range(0, 65535)));
      foreach (vals[j]) begin
         launch(1'b1, vals[j], n);
         wait_done(1'b1, "noprefix");
         tick();
         check_string(1'b1, vals[j], "noprefix");
      end
      bus_b.finish = 1'b0;
   endtask

   task automatic test_busy_ignore();
      int n;
      launch(1'b0, 16'd1234, n);
      tick();
      tick();
      bus_a.finish = 1'b0;
      while (cyc < n + 19) tick();
      bus_a.result = 16'd99;
      bus_a.finish = 1'b1;
      wait_done(1'b0, "busy_ignore");
      repeat (40) tick();
      check_string(1'b0, 16'd1234, "busy_ignore");
      checks++;
      if (done_a.size() != 1) begin
         errors++;
         $display("FAIL busy_ignore_writes: got %0d done pulses want 1", done_a.size());
      end
      launch(1'b0, 16'd99, n);
      wait_done(1'b0, "after_busy");
      tick();
      check_string(1'b0, 16'd99, "after_busy");
   endtask

   task automatic test_hold();
      int          n;
      logic [15:0] v;
      v = 16'($urandom_range(0, 65535));
      launch(1'b0, v, n);
      while (cyc < n + 200) tick();
      check_string(1'b0, v, "hold");
      checks++;
      if (done_a.size() != 1) begin
         errors++;
         $display("FAIL hold_writes: got %0d done pulses want 1", done_a.size());
      end
      bus_a.finish = 1'b0;
   endtask

   task automatic test_reset_mid();
      int          n;
      logic [15:0] v;
      launch(1'b0, 16'd1234, n);
      while (cyc < n + 22) tick();
      rst = 1'b1;
      bus_a.finish = 1'b0;
      tick();
      checks++;
      if (bus_a.char_valid !== 1'b0 || bus_a.busy !== 1'b0 || bus_a.ascii_out !== 8'h00) begin
         errors++;
         $display("FAIL reset_mid: got cv=%b busy=%b ascii=%h want 0 0 00",
                  bus_a.char_valid, bus_a.busy, bus_a.ascii_out);
      end
      rst = 1'b0;
      v = 16'($urandom_range(0, 65535));
      launch(1'b0, v, n);
      wait_done(1'b0, "post_reset");
      tick();
      check_string(1'b0, v, "post_reset");
   endtask

   task automatic test_strobe_rules();
      checks++;
      if (consec_seen !== 1'b0) begin
         errors++;
         $display("FAIL strobe_consecutive: got 1 want 0");
      end
      checks++;
      if (cr_seen !== 1'b0) begin
         errors++;
         $display("FAIL strobe_cr: got 0x0D seen want none");
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_values();
      test_no_prefix();
      test_busy_ignore();
      test_hold();
      test_reset_mid();
      test_strobe_rules();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/result_ascii_writer.md
Name: result_ascii_writer

Overview:
- Writer-side counterpart to the calculator's text-buffer reader: takes the 16-bit calculator result on completion and streams it back to the VGA typewriter as ASCII characters, using the same byte + one-cycle-strobe protocol the keyboard path uses.
- Converts binary to decimal with a sequential double-dabble.
- Emits an optional '=' prefix, then digits MSD-first with leading zeros suppressed.
- Paces strobes so the typewriter cursor logic sees discrete keystrokes.

Parameters:
GAP_CYCLES, 4, idle cycles between consecutive char_valid pulses (legal range 1..255)
EMIT_PREFIX, 1, 1 = emit '=' (0x3D) before the number; 0 = digits only

Ports:
clk_50m  input  1  system clock
rst  input  1  synchronous active-high reset
finish  input  1  calculator completion level/pulse; rising edge starts a write
result  input  16  calculator result, sampled on the finish rising edge
ascii_out  output  8  character code; valid while char_valid=1
char_valid  output  1  one-cycle strobe, drives typewriter dataReady path
busy  output  1  high from start edge until done
done  output  1  one-cycle pulse after the last character's strobe

Behaviour:
- Clock and reset:
  - One clock domain (clk_50m); rst is synchronous, active-high.
  - Reset values: ascii_out=0x00, char_valid=0, busy=0, done=0, finish_d=0, FSM=IDLE, BCD/shift registers cleared.
- Start detection: start = finish & ~finish_d (finish_d is the registered copy of finish).
  - Start is honoured only in IDLE.
  - Start edges while busy=1 are ignored, not queued.
- If start is sampled at edge n:
  - result is latched and busy=1 at edge n.
  - CONVERT performs one double-dabble iteration per edge (add-3 to each nibble >=5, then shift), edges n+1..n+16, giving 5 BCD digits (20 bits).
  - First char_valid is high for the cycle following edge n+17.
- FSM states:
  - IDLE -> CONVERT on start.
  - CONVERT -> EMIT after 16 iterations (4-bit counter).
  - EMIT -> GAP after each strobe.
  - GAP -> EMIT after GAP_CYCLES cycles, if characters remain.
  - GAP -> DONE when the last character has been emitted. GAP still runs its full GAP_CYCLES after the last strobe.
  - DONE -> IDLE after one cycle. done=1 and busy drops to 0 on that same edge.
- Character sequence:
  - [ '=' if EMIT_PREFIX ], then decimal digits 0x30+d.
  - Leading zeros are skipped. The first emitted digit index is fixed at end of CONVERT.
  - Value 0 emits a single '0'.
  - Max 5 digits (65535).
- Strobe rules:
  - char_valid is never high on two consecutive cycles.
  - Strobe starts are GAP_CYCLES+1 clocks apart.
  - ascii_out holds its last emitted code between strobes and after done.
- Never emits 0x0D. CR would retrigger calcStart in the top level.
- rst mid-operation: returns immediately to IDLE with reset values. Any partial string already emitted is not retracted.
- finish held high continuously produces one write only; a new write needs a low-then-high transition.

Optional Feature:
- Macro: SIGNED_RESULT_EN.
- Defined:
  - result is two's complement.
  - If result[15]=1: convert the magnitude (0 - result, 16-bit; 0x8000 -> 32768) and emit '-' (0x2D) after the optional '=' and before the digits.
  - Latency to first strobe is unchanged (negation is done in the latch cycle).
- Undefined: result is unsigned, '-' is never emitted, and no negation logic is synthesised.

Test Plan:
- GAP_CYCLES=4, EMIT_PREFIX=1, result=16'd1234, finish rises at edge n -> strobes at n+17, n+22, n+27, n+32, n+37 carrying 0x3D,0x31,0x32,0x33,0x34; done pulse one cycle after the final GAP, then busy=0.
- result=0 -> exactly two strobes, 0x3D then 0x30. result=16'd65535 -> 0x3D,0x36,0x35,0x35,0x33,0x35. result=16'd7 with EMIT_PREFIX=0 -> single strobe 0x37.
- finish pulsed again at n+20 while busy, result changed to 99 -> output still "=1234"; no second write. Then finish low->high after done -> "=99".
- finish held high for 200 cycles -> exactly one string; char_valid never high on consecutive cycles; no 0x0D ever observed.
- rst asserted at n+23 -> next edge: char_valid=0, busy=0, ascii_out=0x00; a fresh finish edge after reset produces a complete, correct string.
- SIGNED_RESULT_EN defined: result=16'hFFF6 -> 0x3D,0x2D,0x31,0x30; result=16'h8000 -> "=-32768". Undefined: 16'hFFF6 -> "=65526".
